// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter : shares one async SRAM between instruction fetch and MEM stage
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_inst,
  output logic        if_valid,
  input  logic [1:0]  mem_op,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_done,
  output logic        ram_pause,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_drive,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam logic [1:0] c_op_read  = 2'b01;
  localparam logic [1:0] c_op_write = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    WR3  = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  state_t      r_state;
  state_t      w_next;
  kind_t       r_kind;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_if_inst;
  logic [15:0] r_mem_rdata;

  logic w_op_rd;
  logic w_op_wr;
  logic w_done_fetch;
  logic w_done_mem;

  // Reserved encoding 11 matches neither compare and so behaves as "none".
  assign w_op_rd      = (mem_op == c_op_read);
  assign w_op_wr      = (mem_op == c_op_write);
  assign w_done_fetch = (r_state == DONE) && (r_kind == K_FETCH);
  assign w_done_mem   = (r_state == DONE) && (r_kind != K_FETCH);

  always_comb begin
    w_next     = r_state;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_drive = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_op_rd)      w_next = RD1;
        else if (w_op_wr) w_next = WR1;
        else if (if_req)  w_next = RD1;
      end
      RD1: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        w_next    = RD2;
      end
      RD2: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        w_next    = DONE;
      end
      WR1: begin
        sram_ce_n  = 1'b0;
        sram_drive = 1'b1;
        w_next     = WR2;
      end
      WR2: begin
        sram_ce_n  = 1'b0;
        sram_drive = 1'b1;
        sram_we_n  = 1'b0;
        w_next     = WR3;
      end
      WR3: begin
        sram_ce_n  = 1'b0;
        sram_drive = 1'b1;
        w_next     = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_kind      <= K_FETCH;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_if_inst   <= 16'h0000;
      r_mem_rdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_op_rd) begin
          r_kind  <= K_LOAD;
          r_addr  <= mem_addr;
          r_wdata <= mem_wdata;
        end else if (w_op_wr) begin
          r_kind  <= K_STORE;
          r_addr  <= mem_addr;
          r_wdata <= mem_wdata;
        end else if (if_req) begin
          r_kind  <= K_FETCH;
          r_addr  <= if_addr;
          r_wdata <= mem_wdata;
        end
      end
      // Read data is captured on the edge that leaves RD2 and enters DONE.
      if (r_state == RD2) begin
        if (r_kind == K_FETCH) r_if_inst   <= sram_din;
        else                   r_mem_rdata <= sram_din;
      end
    end
  end

  assign sram_addr = r_addr;
  assign sram_dout = r_wdata;
  assign if_inst   = r_if_inst;
  assign mem_rdata = r_mem_rdata;
  assign if_valid  = w_done_fetch;
  assign mem_done  = w_done_mem;
  assign ram_pause = ((w_op_rd || w_op_wr) && !w_done_mem) || (if_req && !w_done_fetch);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: SRAM model, completion scoreboard and directed scenarios.
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_inst;
  logic        if_valid;
  logic [1:0]  mem_op;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        ram_pause;
  logic [15:0] sram_addr;
  logic [15:0] sram_dout;
  logic [15:0] sram_din;
  logic        sram_drive;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .ram_pause(ram_pause),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_drive(sram_drive), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  // Small SRAM model (low address byte only); contents start as 0x6805 ^ index.
  logic [15:0] ram [256];
  logic [15:0] exp_ram [256];
  bit          ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'h6805 ^ 16'(i);
      ram_ready <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      ram[sram_addr[7:0]] <= sram_dout;
    end
  end

  assign sram_din = ram[sram_addr[7:0]];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_mem_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam logic [1:0] K_FETCH = 2'b01;
  localparam logic [1:0] K_MEM   = 2'b10;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic [1:0] kind, input logic [15:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  // Completion monitor: every pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (if_valid || mem_done) begin
      if (mem_done) n_mem_done++;
      if (sb.size() == 0) begin
        check("sb_unexpected_pulse", {30'd0, mem_done, if_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_kind", {30'd0, mem_done, if_valid}, {30'd0, e.kind});
        check("sb_data", if_valid ? if_inst : mem_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] last_load;
  int t_a, t_b, d0;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_op = 2'b00; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 256; i++) exp_ram[i] = 16'h6805 ^ 16'(i);
    last_load = 16'h0000;

    // Reset state
    repeat (3) step();
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_drive", sram_drive, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_if_inst", if_inst, 16'h0000);
    check("rst_mem_rdata", mem_rdata, 16'h0000);
    check("rst_sram_addr", sram_addr, 16'h0000);
    check("rst_sram_dout", sram_dout, 16'h0000);
    check("rst_pause", ram_pause, 0);
    rst = 1'b1;
    step();

    // Fetch only
    if_req = 1'b1; if_addr = 16'h0004;
    push(K_FETCH, exp_ram[8'h04]);
    step();
    check("f_rd1_ce", sram_ce_n, 0);
    check("f_rd1_oe", sram_oe_n, 0);
    check("f_rd1_we", sram_we_n, 1);
    check("f_rd1_drive", sram_drive, 0);
    check("f_rd1_addr", sram_addr, 16'h0004);
    check("f_rd1_pause", ram_pause, 1);
    if_addr = 16'hFFFF;
    step();
    check("f_rd2_addr_latched", sram_addr, 16'h0004);
    check("f_rd2_oe", sram_oe_n, 0);
    check("f_rd2_pause", ram_pause, 1);
    step();
    check("f_done_valid", if_valid, 1);
    check("f_done_inst", if_inst, 16'h6801);
    check("f_done_pause", ram_pause, 0);
    check("f_done_ce", sram_ce_n, 1);
    if_req = 1'b0;
    step();
    check("f_idle_valid", if_valid, 0);
    check("f_idle_inst_hold", if_inst, 16'h6801);

    // Load and fetch requested together: load first, fetch four cycles later
    mem_op = 2'b01; mem_addr = 16'hBF00; if_req = 1'b1; if_addr = 16'h0010;
    push(K_MEM, exp_ram[8'h00]); last_load = exp_ram[8'h00];
    push(K_FETCH, exp_ram[8'h10]);
    t_a = -1; t_b = -1;
    for (int i = 0; i < 20 && t_b < 0; i++) begin
      step();
      if (i == 0) check("cf_load_addr", sram_addr, 16'hBF00);
      if (if_valid) begin
        t_b = cyc;
        check("cf_pause_fetch_done", ram_pause, 0);
        if_req = 1'b0;
      end else begin
        check("cf_pause_held", ram_pause, 1);
      end
      if (mem_done) begin
        t_a = cyc;
        mem_op = 2'b00;
      end
    end
    check("cf_fetch_seen", t_b >= 0, 1);
    check("cf_load_seen", t_a >= 0, 1);
    check("cf_gap", t_b - t_a, 4);
    step();

    // Store
    mem_op = 2'b10; mem_addr = 16'h8000; mem_wdata = 16'h1234;
    push(K_MEM, last_load); exp_ram[8'h00] = 16'h1234;
    step();
    check("st_wr1_we", sram_we_n, 1);
    check("st_wr1_oe", sram_oe_n, 1);
    check("st_wr1_drive", sram_drive, 1);
    check("st_wr1_addr", sram_addr, 16'h8000);
    check("st_wr1_dout", sram_dout, 16'h1234);
    mem_addr = 16'h0000; mem_wdata = 16'hDEAD;
    step();
    check("st_wr2_we", sram_we_n, 0);
    check("st_wr2_oe", sram_oe_n, 1);
    check("st_wr2_addr", sram_addr, 16'h8000);
    check("st_wr2_dout", sram_dout, 16'h1234);
    step();
    check("st_wr3_we", sram_we_n, 1);
    check("st_wr3_drive", sram_drive, 1);
    check("st_wr3_dout", sram_dout, 16'h1234);
    step();
    check("st_done", mem_done, 1);
    check("st_done_drive", sram_drive, 0);
    check("st_rdata_unchanged", mem_rdata, last_load);
    mem_op = 2'b00;
    step();

    // Back-to-back loads, each held until its completion
    mem_op = 2'b01; mem_addr = 16'h8000;
    push(K_MEM, exp_ram[8'h00]); last_load = exp_ram[8'h00];
    d0 = n_mem_done; t_a = -1; t_b = -1;
    for (int i = 0; i < 10 && t_a < 0; i++) begin
      step();
      if (mem_done) begin
        t_a = cyc;
        mem_addr = 16'h0020;
        push(K_MEM, exp_ram[8'h20]); last_load = exp_ram[8'h20];
      end
    end
    check("bb_first_seen", t_a >= 0, 1);
    step();
    check("bb_turnaround_idle", sram_ce_n, 1);
    step();
    check("bb_second_addr", sram_addr, 16'h0020);
    check("bb_second_ce", sram_ce_n, 0);
    for (int i = 0; i < 10 && t_b < 0; i++) begin
      step();
      if (mem_done) begin
        t_b = cyc;
        mem_op = 2'b00;
      end
    end
    check("bb_second_seen", t_b >= 0, 1);
    check("bb_gap", t_b - t_a, 4);
    repeat (4) step();
    check("bb_done_count", n_mem_done - d0, 2);
    check("bb_rdata_hold", mem_rdata, last_load);

    // Reset in the middle of a write
    mem_op = 2'b10; mem_addr = 16'h0030; mem_wdata = 16'h5555;
    exp_ram[8'h30] = 16'h5555;
    d0 = n_mem_done;
    step();
    mem_op = 2'b00;
    step();
    check("rw_wr2_we", sram_we_n, 0);
    rst = 1'b0;
    step();
    check("rw_we_released", sram_we_n, 1);
    check("rw_drive", sram_drive, 0);
    check("rw_ce", sram_ce_n, 1);
    check("rw_mem_done", mem_done, 0);
    check("rw_rdata_cleared", mem_rdata, 16'h0000);
    check("rw_inst_cleared", if_inst, 16'h0000);
    check("rw_addr_cleared", sram_addr, 16'h0000);
    rst = 1'b1;
    repeat (4) step();
    check("rw_no_done", n_mem_done - d0, 0);
    last_load = 16'h0000;

    // Reserved op with no fetch: stays idle
    mem_op = 2'b11; mem_addr = 16'h1111; if_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rsv_pause", ram_pause, 0);
      check("rsv_ce", sram_ce_n, 1);
      check("rsv_we", sram_we_n, 1);
      check("rsv_drive", sram_drive, 0);
    end
    mem_op = 2'b00;
    repeat (3) step();
    check("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
